cp0_reg: RTL

CP0_REG -- requirements
Module: cp0_reg

---
 rtl/cp0_reg_pkg.sv | 45 ++++
 rtl/cp0_reg_if.sv | 39 +++
 rtl/cp0_timer.sv | 66 ++++++
 rtl/cp0_reg.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/cp0_reg_pkg.sv
// CP0 register numbers, Status/Cause field positions and exception codes.
// Shared by the CP0 block, its interface and its bench.
package cp0_reg_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int EXC_CODE_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [EXC_CODE_W-1:0] exc_code_t;

  localparam reg_addr_t CP0_BADVADDR = 5'd8;
  localparam reg_addr_t CP0_COUNT    = 5'd9;
  localparam reg_addr_t CP0_COMPARE  = 5'd11;
  localparam reg_addr_t CP0_STATUS   = 5'd12;
  localparam reg_addr_t CP0_CAUSE    = 5'd13;
  localparam reg_addr_t CP0_EPC      = 5'd14;

  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;
  localparam int ST_IM_HI = 15;
  localparam int ST_BEV   = 22;

  localparam int CA_EXC_LO = 2;
  localparam int CA_EXC_HI = 6;
  localparam int CA_IP_LO  = 8;
  localparam int CA_IP_HI  = 15;
  localparam int CA_TI     = 30;
  localparam int CA_BD     = 31;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

  typedef enum logic [EXC_CODE_W-1:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_OV   = 5'd12
  } exc_code_e;

  // Only address errors carry a meaningful faulting address.
  function automatic logic is_addr_err(input exc_code_t code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_reg_if.sv
// Pipeline-facing bundle of the CP0 block: EXE read, WB write, MEM exception/ERET
// commit, interrupt lines, and the flush redirect back to fetch.
interface cp0_reg_if;
  import cp0_reg_pkg::*;

  logic        cp0_re;
  reg_addr_t   cp0_addr;
  logic [31:0] cp0_data_o;

  logic        wb_wc0;
  reg_addr_t   wb_cp0addr;
  logic [31:0] wb_cp0wdata;

  logic        exc_valid;
  exc_code_t   exc_code;
  logic [31:0] exc_pc;
  logic        exc_in_ds;
  logic [31:0] exc_badvaddr;
  logic        eret_valid;

  logic [5:0]  int_i;
  logic        int_req;

  logic        flush;
  logic [31:0] flush_pc;

  modport master (
    output cp0_re, cp0_addr, wb_wc0, wb_cp0addr, wb_cp0wdata,
           exc_valid, exc_code, exc_pc, exc_in_ds, exc_badvaddr, eret_valid, int_i,
    input  cp0_data_o, int_req, flush, flush_pc
  );

  modport slave (
    input  cp0_re, cp0_addr, wb_wc0, wb_cp0addr, wb_cp0wdata,
           exc_valid, exc_code, exc_pc, exc_in_ds, exc_badvaddr, eret_valid, int_i,
    output cp0_data_o, int_req, flush, flush_pc
  );

endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled free-running Count, Compare match raises TI.
// MTC0 to Count restarts the prescaler; MTC0 to Compare clears TI and beats a same-edge match.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_count_i,
  input  logic        wr_compare_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [31:0]      count_q, count_d;
  logic [31:0]      compare_q, compare_d;
  logic             ti_q, ti_d;
  logic             inc;
  logic [31:0]      count_inc;

  assign inc       = (div_q == DIV_LAST);
  assign count_inc = count_q + 32'd1;

  always_comb begin
    div_d     = inc ? '0 : div_q + 1'b1;
    count_d   = inc ? count_inc : count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    // A loaded Count never raises TI by itself; only a real increment can.
    if (inc && !wr_count_i && (count_inc == compare_q)) begin
      ti_d = 1'b1;
    end
    if (wr_count_i) begin
      count_d = wdata_i;
      div_d   = '0;
    end
    if (wr_compare_i) begin
      compare_d = wdata_i;
      ti_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_reg.sv
// CP0 register file: Status/Cause/EPC/BadVAddr plus timer, exception/ERET commit and flush.
// Reads are combinational; flush is a registered one-cycle pulse after the committing event.
module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int          COUNT_DIV  = 2
) (
  input  logic     clk,
  input  logic     reset,
  cp0_reg_if.slave bus
);

  logic [7:0]      im_q, im_d;
  logic            exl_q, exl_d;
  logic            ie_q, ie_d;
  logic            bd_q, bd_d;
  logic [1:0]      ip_sw_q, ip_sw_d;
  logic [4:0]      ip_hw_q, ip_hw_d;
  exc_code_t       exc_code_q, exc_code_d;
  logic [31:0]     epc_q, epc_d;
  logic [31:0]     badvaddr_q, badvaddr_d;
  logic            flush_q, flush_d;
  logic [31:0]     flush_pc_q, flush_pc_d;

  logic            wr_count, wr_compare;
  logic [31:0]     count, compare;
  logic            ti;
  logic [7:0]      cause_ip;
  logic [31:0]     status_rd, cause_rd, rd_data;
  logic            int5_unused;

  // int_i[5] is shared with the timer interrupt, so the line itself is not observed.
  assign int5_unused = bus.int_i[5];

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .wr_count_i   (wr_count),
    .wr_compare_i (wr_compare),
    .wdata_i      (bus.wb_cp0wdata),
    .count_o      (count),
    .compare_o    (compare),
    .ti_o         (ti)
  );

  // Priority: exception, then ERET, then MTC0; the loser is discarded outright.
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    ip_hw_d    = bus.int_i[4:0];
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    flush_d    = 1'b0;
    flush_pc_d = flush_pc_q;
    wr_count   = 1'b0;
    wr_compare = 1'b0;
    if (bus.exc_valid) begin
      if (!exl_q) begin
        epc_d = bus.exc_in_ds ? (bus.exc_pc - 32'd4) : bus.exc_pc;
        bd_d  = bus.exc_in_ds;
      end
      exl_d      = 1'b1;
      exc_code_d = bus.exc_code;
      if (is_addr_err(bus.exc_code)) begin
        badvaddr_d = bus.exc_badvaddr;
      end
      flush_d    = 1'b1;
      flush_pc_d = EXC_VECTOR;
    end else if (bus.eret_valid) begin
      exl_d      = 1'b0;
      flush_d    = 1'b1;
      flush_pc_d = epc_q;
    end else if (bus.wb_wc0) begin
      case (bus.wb_cp0addr)
        CP0_COUNT:   wr_count   = 1'b1;
        CP0_COMPARE: wr_compare = 1'b1;
        CP0_STATUS: begin
          im_d  = bus.wb_cp0wdata[ST_IM_HI:ST_IM_LO];
          exl_d = bus.wb_cp0wdata[ST_EXL];
          ie_d  = bus.wb_cp0wdata[ST_IE];
        end
        CP0_CAUSE:   ip_sw_d = bus.wb_cp0wdata[CA_IP_LO+1:CA_IP_LO];
        CP0_EPC:     epc_d   = bus.wb_cp0wdata;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= ip_hw_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  assign cause_ip = {ti, ip_hw_q, ip_sw_q};

  always_comb begin
    status_rd                    = '0;
    status_rd[ST_BEV]            = 1'b1;
    status_rd[ST_IM_HI:ST_IM_LO] = im_q;
    status_rd[ST_EXL]            = exl_q;
    status_rd[ST_IE]             = ie_q;
  end

  always_comb begin
    cause_rd                      = '0;
    cause_rd[CA_BD]               = bd_q;
    cause_rd[CA_TI]               = ti;
    cause_rd[CA_IP_HI:CA_IP_LO]   = cause_ip;
    cause_rd[CA_EXC_HI:CA_EXC_LO] = exc_code_q;
  end

  always_comb begin
    rd_data = '0;
    if (bus.cp0_re) begin
      case (bus.cp0_addr)
        CP0_BADVADDR: rd_data = badvaddr_q;
        CP0_COUNT:    rd_data = count;
        CP0_COMPARE:  rd_data = compare;
        CP0_STATUS:   rd_data = status_rd;
        CP0_CAUSE:    rd_data = cause_rd;
        CP0_EPC:      rd_data = epc_q;
        default:      rd_data = '0;
      endcase
    end
  end

  assign bus.cp0_data_o = rd_data;
  assign bus.int_req    = ie_q & ~exl_q & (|(im_q & cause_ip));
  assign bus.flush      = flush_q;
  assign bus.flush_pc   = flush_pc_q;

endmodule
